// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the data memory (slave).
// The memory signals completion with a one-cycle dmem_resp pulse.
interface mem_access_stage_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_address,
        output dmem_wdata,
        output dmem_byte_enable,
        input  dmem_rdata,
        input  dmem_resp
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_address,
        input  dmem_wdata,
        input  dmem_byte_enable,
        output dmem_rdata,
        output dmem_resp
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores, builds byte lanes, extends load data,
// and stalls the pipeline until the memory responds or the optional timeout aborts the access.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MEM_valid,
    input  logic                      MEM_mem_read,
    input  logic                      MEM_mem_write,
    input  logic [2:0]                MEM_funct3,
    input  logic [31:0]               MEM_alu_out,
    input  logic [31:0]               MEM_rs2_out,
    mem_access_stage_if.master        dmem,
    output logic [31:0]               MEM_rdata,
    output logic                      MEM_stall,
    output logic                      MEM_misaligned,
    output logic                      MEM_bus_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              bus_error_q, bus_error_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req;
    logic              is_write;
    logic              misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_ext;
    logic              in_access;

    // Decode the incoming instruction; a load+store combination is treated as a store.
    always_comb begin
        req       = MEM_valid & (MEM_mem_read | MEM_mem_write);
        is_write  = MEM_mem_write;
        be_new    = 4'hF;
        wdata_new = MEM_rs2_out;
        case (MEM_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = MEM_alu_out[0];
            default: misaligned = |MEM_alu_out[1:0];
        endcase
        if (is_write) begin
            case (MEM_funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << MEM_alu_out[1:0];
                    wdata_new = {4{MEM_rs2_out[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << MEM_alu_out[1:0];
                    wdata_new = {2{MEM_rs2_out[15:0]}};
                end
                default: begin
                    be_new    = 4'hF;
                    wdata_new = MEM_rs2_out;
                end
            endcase
        end
    end

    // Load alignment uses the latched offset/width, since the EX inputs may move on.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_byte = dmem.dmem_rdata[7:0];
            2'b01:   lane_byte = dmem.dmem_rdata[15:8];
            2'b10:   lane_byte = dmem.dmem_rdata[23:16];
            default: lane_byte = dmem.dmem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h000000, lane_byte};
            3'b101:  load_ext = {16'h0000, lane_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        read_d      = read_q;
        write_d     = write_q;
        bus_error_d = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (req && !misaligned) begin
                    state_d  = ACCESS;
                    addr_d   = MEM_alu_out;
                    wdata_d  = is_write ? wdata_new : 32'h0;
                    be_d     = be_new;
                    funct3_d = MEM_funct3;
                    cnt_d    = '0;
                    read_d   = ~is_write;
                    write_d  = is_write;
                end
            end
            ACCESS: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        rdata_d = load_ext;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = DONE;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    bus_error_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            funct3_q    <= 3'b000;
            cnt_q       <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            bus_error_q <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            read_q      <= read_d;
            write_q     <= write_d;
            bus_error_q <= bus_error_d;
            rdata_q     <= rdata_d;
        end
    end

    // Bus lanes are only presented while a request is outstanding.
    assign in_access             = (state_q == ACCESS);
    assign dmem.dmem_read        = read_q;
    assign dmem.dmem_write       = write_q;
    assign dmem.dmem_address     = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem.dmem_wdata       = in_access ? wdata_q : 32'h0;
    assign dmem.dmem_byte_enable = in_access ? be_q : 4'h0;

    assign MEM_rdata      = rdata_q;
    assign MEM_bus_error  = bus_error_q;
    assign MEM_stall      = rst_n & (((state_q == IDLE) & req & ~misaligned) | in_access);
    assign MEM_misaligned = rst_n & (state_q == IDLE) & req & misaligned;

endmodule
